// File: rtl/trajectory_judge_stream.sv
// Streaming trajectory judge: checks each waypoint's joints (one per cycle) against grid bounds and step limit,
// then reports a deadline code. Optional acceleration check enabled by defining TRAJ_JUDGE_ACCEL_EN.
module trajectory_judge_stream #(
  parameter int unsigned STEPPERS_NUM = 6,
  parameter int unsigned POS_W        = 32,
  parameter int unsigned GRID_WIDTH   = 65536,
  parameter int unsigned MAX_STEP     = 16,
`ifdef TRAJ_JUDGE_ACCEL_EN
  parameter int unsigned MAX_ACC      = 4,
`endif
  parameter int unsigned DL_W         = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wp_valid,
  output logic                          wp_ready,
  input  logic                          wp_last,
  input  logic [POS_W*STEPPERS_NUM-1:0] wp_position,
  output logic                          busy,
  output logic [DL_W-1:0]               deadline,
  output logic                          deadline_valid
);

  localparam int unsigned SW = POS_W + 1;
  localparam int unsigned KW = (STEPPERS_NUM > 1) ? $clog2(STEPPERS_NUM) : 1;
`ifdef TRAJ_JUDGE_ACCEL_EN
  localparam int unsigned AW = SW + 1;
`endif

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  state_t           state;
  logic [POS_W-1:0] pos_q  [STEPPERS_NUM];
  logic [POS_W-1:0] prev_q [STEPPERS_NUM];
  logic             last_q;
  logic [KW-1:0]    k_q;
  logic [DL_W-1:0]  n_q;
  logic [DL_W-1:0]  viol_idx_q;
  logic             viol_q;
`ifdef TRAJ_JUDGE_ACCEL_EN
  logic signed [SW-1:0] pdelta_q [STEPPERS_NUM];
  logic signed [AW-1:0] acc_c;
  logic [AW-1:0]        acc_mag_c;
`endif

  logic [POS_W-1:0]     cur_c;
  logic [POS_W-1:0]     prev_c;
  logic signed [SW-1:0] delta_c;
  logic [SW-1:0]        step_mag_c;
  logic                 bound_bad_c;
  logic                 step_bad_c;
  logic                 accel_bad_c;
  logic                 bad_c;
  logic [DL_W-1:0]      code_c;

  // Check of the joint selected by k_q against the previous waypoint
  always_comb begin
    cur_c       = pos_q[k_q];
    prev_c      = prev_q[k_q];
    delta_c     = $signed({1'b0, cur_c}) - $signed({1'b0, prev_c});
    step_mag_c  = delta_c[SW-1] ? SW'(-delta_c) : SW'(delta_c);
    bound_bad_c = 64'(cur_c) >= 64'(GRID_WIDTH);
    step_bad_c  = (n_q != '0) && (step_mag_c > SW'(MAX_STEP));
`ifdef TRAJ_JUDGE_ACCEL_EN
    acc_c       = $signed({delta_c[SW-1], delta_c}) - $signed({pdelta_q[k_q][SW-1], pdelta_q[k_q]});
    acc_mag_c   = acc_c[AW-1] ? AW'(-acc_c) : AW'(acc_c);
    accel_bad_c = (n_q >= DL_W'(2)) && (acc_mag_c > AW'(MAX_ACC));
`else
    accel_bad_c = 1'b0;
`endif
    bad_c       = bound_bad_c | step_bad_c | accel_bad_c;
  end

  // A clamped violation index stops one short of the all-ones success code
  always_comb begin
    code_c = '1;
    if (viol_q) begin
      if (viol_idx_q == '1) code_c = viol_idx_q - DL_W'(1);
      else                  code_c = viol_idx_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      wp_ready       <= 1'b1;
      busy           <= 1'b0;
      deadline       <= '0;
      deadline_valid <= 1'b0;
      last_q         <= 1'b0;
      k_q            <= '0;
      n_q            <= '0;
      viol_q         <= 1'b0;
      viol_idx_q     <= '0;
      for (int i = 0; i < STEPPERS_NUM; i++) begin
        pos_q[i]    <= '0;
        prev_q[i]   <= '0;
`ifdef TRAJ_JUDGE_ACCEL_EN
        pdelta_q[i] <= '0;
`endif
      end
    end else begin
      deadline_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wp_valid && wp_ready) begin
            for (int i = 0; i < STEPPERS_NUM; i++) pos_q[i] <= wp_position[POS_W*i +: POS_W];
            last_q   <= wp_last;
            k_q      <= '0;
            wp_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          // After the first violation the rest of the trajectory only drains
          if (!viol_q && bad_c) begin
            viol_q     <= 1'b1;
            viol_idx_q <= n_q;
          end
          prev_q[k_q]   <= cur_c;
`ifdef TRAJ_JUDGE_ACCEL_EN
          pdelta_q[k_q] <= delta_c;
`endif
          if (k_q == KW'(STEPPERS_NUM - 1)) begin
            if (last_q) begin
              state <= REPORT;
            end else begin
              state    <= IDLE;
              wp_ready <= 1'b1;
              n_q      <= (n_q == '1) ? n_q : n_q + DL_W'(1);
            end
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        REPORT: begin
          deadline       <= code_c;
          deadline_valid <= 1'b1;
          busy           <= 1'b0;
          wp_ready       <= 1'b1;
          n_q            <= '0;
          viol_q         <= 1'b0;
          viol_idx_q     <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trajectory_judge_stream.sv
// Self-checking bench for trajectory_judge_stream: directed cases plus random trajectories against a waypoint-level model.
module tb_trajectory_judge_stream;

  localparam int unsigned SN  = 6;
  localparam int unsigned PW  = 32;
  localparam int unsigned DLW = 8;

  typedef logic [SN*PW-1:0] wp_t;
  typedef struct { int due; int code; } exp_t;

  logic            CLK;
  logic            RST;
  logic            wp_valid;
  logic            wp_ready;
  logic            wp_last;
  wp_t             wp_position;
  logic            busy;
  logic [DLW-1:0]  deadline;
  logic            deadline_valid;

  int             total = 0;
  int             bad   = 0;
  int             cyc   = 0;
  exp_t           expq[$];
  exp_t           mon_e;
  logic [DLW-1:0] held = '0;
  wp_t            traj[$];

  trajectory_judge_stream dut (
    .CLK(CLK), .RST(RST), .wp_valid(wp_valid), .wp_ready(wp_ready), .wp_last(wp_last),
    .wp_position(wp_position), .busy(busy), .deadline(deadline), .deadline_valid(deadline_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Reports: correct code, exact cycle, one-cycle pulse, value held in between
  always @(negedge CLK) begin
    if (RST) begin
      expq.delete();
      held = '0;
    end else if (deadline_valid) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_report got=%0d cyc=%0d", deadline, cyc);
      end else begin
        mon_e = expq.pop_front();
        if (int'(deadline) != mon_e.code || cyc != mon_e.due) begin
          bad++;
          $display("FAIL report got=%0d@%0d want=%0d@%0d", deadline, cyc, mon_e.code, mon_e.due);
        end
      end
      held = deadline;
    end else begin
      total++;
      if (deadline !== held) begin
        bad++;
        $display("FAIL deadline_hold got=%0d want=%0d", deadline, held);
      end
      if (expq.size() > 0 && cyc > expq[0].due) begin
        total++;
        bad++;
        $display("FAIL missing_report want=%0d@%0d", expq[0].code, expq[0].due);
        void'(expq.pop_front());
      end
    end
  end

  function automatic wp_t all_joints(input int v);
    wp_t w;
    for (int k = 0; k < int'(SN); k++) w[PW*k +: PW] = PW'(v);
    return w;
  endfunction

  function automatic wp_t one_joint(input int k, input int v);
    wp_t w;
    w = '0;
    w[PW*k +: PW] = PW'(v);
    return w;
  endfunction

  // Waypoint-level reference: first waypoint index with any bad joint
  function automatic int model_code();
    longint prev[SN];
    longint pd[SN];
    longint p, d, a;
    int     v;
    bit     b;
    wp_t    w;
    v = -1;
    for (int k = 0; k < int'(SN); k++) begin prev[k] = 0; pd[k] = 0; end
    for (int n = 0; n < traj.size(); n++) begin
      w = traj[n];
      b = 1'b0;
      for (int k = 0; k < int'(SN); k++) begin
        p = longint'(w[PW*k +: PW]);
        if (p >= 65536) b = 1'b1;
        d = p - prev[k];
        if (n >= 1 && (d < 0 ? -d : d) > 16) b = 1'b1;
`ifdef TRAJ_JUDGE_ACCEL_EN
        a = d - pd[k];
        if (n >= 2 && (a < 0 ? -a : a) > 4) b = 1'b1;
`else
        a = 0;
`endif
        pd[k]   = d + a - a;
        prev[k] = p;
      end
      if (b && v < 0) v = n;
    end
    if (v < 0)   return 255;
    if (v == 0)  return 0;
    if (v > 254) return 254;
    return v;
  endfunction

  task automatic send(input wp_t p, input bit last, output int acc);
    int guard;
    guard = 0;
    acc = -1;
    wp_position = p;
    wp_last = last;
    wp_valid = 1'b1;
    while (!wp_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (!wp_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout cyc=%0d", cyc);
      wp_valid = 1'b0;
    end else begin
      acc = cyc;
      @(negedge CLK);
      wp_valid = 1'b0;
    end
  endtask

  task automatic run_traj(input int lit, input bit gaps);
    int acc, prev_acc, m, code, g;
    bit gapped;
    m = model_code();
    if (lit >= 0) begin
      chk("model_pin", m, lit);
      code = lit;
    end else begin
      code = m;
    end
    prev_acc = -1;
    for (int n = 0; n < traj.size(); n++) begin
      gapped = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 9)) @(negedge CLK);
        gapped = 1'b1;
      end
      send(traj[n], n == traj.size() - 1, acc);
      if (acc < 0) break;
      if (n == 0) chk("busy_high", longint'(busy), 1);
      if (n > 0 && !gapped) chk("accept_spacing", acc - prev_acc, int'(SN) + 1);
      if (n == traj.size() - 1) expq.push_back('{acc + int'(SN) + 2, code});
      prev_acc = acc;
    end
    g = 0;
    while (expq.size() > 0 && g < 40) begin
      @(negedge CLK);
      g++;
    end
    @(negedge CLK);
    chk("busy_low", longint'(busy), 0);
  endtask

  task automatic gen_rand();
    longint p[SN];
    int     len;
    wp_t    w;
    traj.delete();
    len = int'($urandom_range(1, 8));
    for (int k = 0; k < int'(SN); k++) p[k] = 1000 + longint'($urandom_range(0, 3000));
    for (int n = 0; n < len; n++) begin
      for (int k = 0; k < int'(SN); k++) begin
        if (n > 0) begin
          if ($urandom_range(0, 99) < 90) p[k] += longint'(int'($urandom_range(0, 32)) - 16);
          else p[k] += ($urandom_range(0, 1) != 0) ? 17 : -18;
        end
        if ($urandom_range(0, 99) < 2) p[k] = 65535 + longint'($urandom_range(0, 2));
        w[PW*k +: PW] = PW'(p[k]);
      end
      traj.push_back(w);
    end
  endtask

  initial begin
    int acc;
    wp_t w;
    RST = 1'b1;
    wp_valid = 1'b0;
    wp_last = 1'b0;
    wp_position = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", longint'(wp_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_deadline", longint'(deadline), 0);
    chk("rst_dvalid", longint'(deadline_valid), 0);
    RST = 1'b0;
    @(negedge CLK);

    traj.delete();
    for (int i = 0; i < 4; i++) traj.push_back(all_joints(100 + 10 * i));
    run_traj(255, 1'b0);

    traj.delete();
    w = all_joints(0);
    w[PW*3 +: PW] = PW'(65536);
    traj.push_back(w);
    traj.push_back(all_joints(0));
    traj.push_back(all_joints(0));
    run_traj(0, 1'b0);

    traj.delete();
    traj.push_back(one_joint(0, 100));
    traj.push_back(one_joint(0, 116));
    for (int i = 0; i < 3; i++) traj.push_back(one_joint(0, 133));
    run_traj(2, 1'b0);

    traj.delete();
    for (int i = 0; i < 300; i++) begin
      w = all_joints(500);
      if (i >= 280) w[PW*2 +: PW] = PW'(600);
      traj.push_back(w);
    end
    run_traj(254, 1'b0);

    traj.delete();
    traj.push_back(one_joint(0, 0));
    traj.push_back(one_joint(0, 2));
    traj.push_back(one_joint(0, 8));
`ifdef TRAJ_JUDGE_ACCEL_EN
    run_traj(-1, 1'b0);
`else
    run_traj(255, 1'b0);
`endif

    traj.delete();
    traj.push_back(one_joint(5, 65535));
    run_traj(255, 1'b0);
    traj.delete();
    traj.push_back(one_joint(5, 65536));
    run_traj(0, 1'b0);

    // Abort a trajectory while its second waypoint is being checked
    send(all_joints(100), 1'b0, acc);
    send(all_joints(105), 1'b0, acc);
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    chk("abort_ready", longint'(wp_ready), 1);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_deadline", longint'(deadline), 0);
    chk("abort_dvalid", longint'(deadline_valid), 0);
    repeat (12) @(negedge CLK);
    traj.delete();
    traj.push_back(all_joints(40000));
    run_traj(255, 1'b0);

    for (int t = 0; t < 40; t++) begin
      gen_rand();
      run_traj(-1, 1'b1);
    end

    repeat (5) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
